// File: rtl/jk_mod_counter_pkg.sv
// jk_mod_counter_pkg
//
// Shared definitions for the JK-cell modulo counter and its cells:
//   - count direction constants (DIR_UP / DIR_DOWN) as seen on up_down
//   - JK excitation encodings, packed as {J, K}
//   - helpers that turn a desired bit transition into a {J, K} pair
//
// No ports; imported by jk_cell and jk_mod_counter.

package jk_mod_counter_pkg;

    // Direction as sampled on up_down.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // JK excitation encodings, packed as {J, K}.
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Counting only ever toggles or holds a cell: J=K=1 if the bit changes, else J=K=0.
    function automatic logic [1:0] jk_count_exc(input logic cur, input logic nxt);
        return (cur != nxt) ? JK_TOGGLE : JK_HOLD;
    endfunction

    // Parallel load drives J=d, K=~d so the cell takes d regardless of its old value.
    function automatic logic [1:0] jk_load_exc(input logic d);
        return d ? JK_SET : JK_RESET;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// jk_cell
//
// Single JK flip-flop with synchronous active-high reset.
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high reset, forces q to 0
//   j, k   in   excitation: 00 hold, 01 reset, 10 set, 11 toggle
//   q      out  stored bit
//   qnot   out  complement of q

module jk_cell
    import jk_mod_counter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qnot
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = q_q;
        case ({j, k})
            JK_HOLD:   q_d = q_q;
            JK_RESET:  q_d = 1'b0;
            JK_SET:    q_d = 1'b1;
            JK_TOGGLE: q_d = ~q_q;
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign qnot = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter
//
// Synchronous modulo-MODULUS up/down counter whose state is held in WIDTH
// jk_cell instances. This module computes the J/K excitation for every cell
// and reads the cells' Q/Qnot back as the count.
//
// Parameters:
//   WIDTH    number of JK cells (count width)
//   MODULUS  count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset
//   enable      in   count enable
//   up_down     in   1 = count up, 0 = count down
//   load        in   synchronous parallel load (priority over enable)
//   load_value  in   value to load; out-of-range values load MODULUS-1
//   count       out  current count (Q of the cells)
//   tc          out  combinational terminal count for the current direction
//   carry       out  registered one-cycle wrap pulse
//   load_err    out  registered one-cycle out-of-range-load flag
//
// Build option:
//   JKC_ONESHOT_EN  when defined the counter saturates at the terminal value
//                   (MODULUS-1 up, 0 down) instead of wrapping; carry pulses
//                   on the edge that reaches the terminal value.

module jk_mod_counter
    import jk_mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             carry,
    output logic             load_err
);

    // Reject illegal configurations at elaboration.
    if ((MODULUS < 2) || (64'(MODULUS) > (64'(1) << WIDTH))) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] CountMax = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);
    // One extra bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   ModExt   = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic [WIDTH-1:0] next_count;

    logic at_max;
    logic at_zero;
    logic illegal;

    logic carry_d;
    logic carry_q;
    logic load_err_d;
    logic load_err_q;

    assign at_max  = (count == CountMax);
    assign at_zero = &count_n;
    // Only reachable if a cell is forced from outside.
    assign illegal = ({1'b0, count} >= ModExt);

    assign tc = enable & (((up_down == DIR_UP) & at_max) | ((up_down == DIR_DOWN) & at_zero));

    // Next-count selection and excitation. Reset is applied inside the cells
    // and the output flops, so the excitation is don't-care on a reset edge.
    always_comb begin
        next_count = count;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
        j_vec      = '0;
        k_vec      = '0;

        if (load) begin
            if (load_value > CountMax) begin
                next_count = CountMax;
                load_err_d = 1'b1;
            end else begin
                next_count = load_value;
            end
            for (int i = 0; i < WIDTH; i++) begin
                {j_vec[i], k_vec[i]} = jk_load_exc(next_count[i]);
            end
        end else if (enable) begin
            if (illegal) begin
                next_count = '0;
            end else if (up_down == DIR_UP) begin
`ifdef JKC_ONESHOT_EN
                // Saturate at the top; carry flags the edge that arrives there.
                if (!at_max) begin
                    next_count = count + CountOne;
                    carry_d    = (next_count == CountMax);
                end
`else
                if (at_max) begin
                    next_count = '0;
                    carry_d    = 1'b1;
                end else begin
                    next_count = count + CountOne;
                end
`endif
            end else begin
`ifdef JKC_ONESHOT_EN
                // Saturate at zero; carry flags the edge that arrives there.
                if (!at_zero) begin
                    next_count = count - CountOne;
                    carry_d    = (next_count == '0);
                end
`else
                if (at_zero) begin
                    next_count = CountMax;
                    carry_d    = 1'b1;
                end else begin
                    next_count = count - CountOne;
                end
`endif
            end
            for (int i = 0; i < WIDTH; i++) begin
                {j_vec[i], k_vec[i]} = jk_count_exc(count[i], next_count[i]);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign carry    = carry_q;
    assign load_err = load_err_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cells
        jk_cell u_cell (
            .clock (clock),
            .reset (reset),
            .j     (j_vec[i]),
            .k     (k_vec[i]),
            .q     (count[i]),
            .qnot  (count_n[i])
        );
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter
//
// Directed bench for jk_mod_counter with WIDTH=4, MODULUS=10. Inputs change
// 1 time unit after the rising edge and outputs are checked there as well.
// Wrap sequences are checked in the default build; the saturating sequence
// is checked when JKC_ONESHOT_EN is defined.

module tb_jk_mod_counter;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] count;
    logic       tc;
    logic       carry;
    logic       load_err;

    int checks = 0;
    int errors = 0;

    jk_mod_counter #(
        .WIDTH   (4),
        .MODULUS (10)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .tc         (tc),
        .carry      (carry),
        .load_err   (load_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    int up_cnt[12]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int up_tc[12]    = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int up_carry[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int dn_cnt[4]    = '{1, 0, 9, 8};
    int dn_tc[4]     = '{0, 1, 0, 0};
    int dn_carry[4]  = '{0, 0, 1, 0};
    int os_cnt[5]    = '{8, 9, 9, 9, 9};
    int os_carry[5]  = '{0, 1, 0, 0, 0};

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        up_down    = 1'b1;
        load       = 1'b1;
        load_value = 4'd7;

        // Reset overrides load and enable.
        for (int e = 0; e < 2; e++) begin
            step();
            chk("reset_count", int'(count), 0);
            chk("reset_carry", int'(carry), 0);
            chk("reset_load_err", int'(load_err), 0);
        end

        reset = 1'b0;
        load  = 1'b0;
        #1;
        chk("tc_at_zero_up", int'(tc), 0);

`ifndef JKC_ONESHOT_EN
        // Up count through the wrap.
        for (int e = 0; e < 12; e++) begin
            step();
            chk("up_count", int'(count), up_cnt[e]);
            chk("up_tc", int'(tc), up_tc[e]);
            chk("up_carry", int'(carry), up_carry[e]);
        end

        // Down count through the wrap.
        load       = 1'b1;
        load_value = 4'd2;
        step();
        chk("load2_count", int'(count), 2);
        chk("load2_carry", int'(carry), 0);
        load    = 1'b0;
        up_down = 1'b0;
        for (int e = 0; e < 4; e++) begin
            step();
            chk("dn_count", int'(count), dn_cnt[e]);
            chk("dn_tc", int'(tc), dn_tc[e]);
            chk("dn_carry", int'(carry), dn_carry[e]);
        end
`endif

        // Out-of-range load clamps to MODULUS-1 and flags for one cycle.
        enable     = 1'b0;
        load       = 1'b1;
        load_value = 4'd13;
        step();
        chk("oor_count", int'(count), 9);
        chk("oor_load_err", int'(load_err), 1);
        chk("oor_carry", int'(carry), 0);
        load = 1'b0;
        step();
        chk("oor_count_hold", int'(count), 9);
        chk("oor_load_err_clear", int'(load_err), 0);

        // Load wins over enable; no increment on that edge.
        enable     = 1'b1;
        up_down    = 1'b1;
        load       = 1'b1;
        load_value = 4'd4;
        step();
        chk("coll_count", int'(count), 4);
        chk("coll_carry", int'(carry), 0);
        load   = 1'b0;
        enable = 1'b0;
        for (int e = 0; e < 3; e++) begin
            step();
            chk("hold_count", int'(count), 4);
            chk("hold_carry", int'(carry), 0);
            chk("hold_tc", int'(tc), 0);
        end

        // tc is combinational in enable and up_down.
        load       = 1'b1;
        load_value = 4'd9;
        step();
        load = 1'b0;
        #1;
        chk("tc_9_disabled", int'(tc), 0);
        enable = 1'b1;
        #1;
        chk("tc_9_up", int'(tc), 1);
        up_down = 1'b0;
        #1;
        chk("tc_9_down", int'(tc), 0);

        // Reset mid-count.
        reset = 1'b1;
        step();
        chk("midreset_count", int'(count), 0);
        chk("midreset_carry", int'(carry), 0);
        reset = 1'b0;

`ifdef JKC_ONESHOT_EN
        // Saturating count from 7.
        load       = 1'b1;
        load_value = 4'd7;
        up_down    = 1'b1;
        step();
        chk("os_load_count", int'(count), 7);
        load = 1'b0;
        for (int e = 0; e < 5; e++) begin
            step();
            chk("os_count", int'(count), os_cnt[e]);
            chk("os_carry", int'(carry), os_carry[e]);
        end
        up_down = 1'b0;
        step();
        chk("os_reverse_count", int'(count), 8);
        chk("os_reverse_carry", int'(carry), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
